// File: rtl/pipe_monitor_pkg.sv
// Shared types and helpers for the pipeline-activity monitor.
package pipe_monitor_pkg;

  localparam int STATE_W = 2;

  // Monitor phases; HALT is left only through reset.
  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Counter-select width: NSTAGE stage counters plus one cycle counter.
  function automatic int sel_width(input int nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/pipe_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count register with synchronous active-low reset and clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_monitor.sv
// Pipeline-activity monitor: per-stage and cycle counters, pass/fail
// detection by fetch PC, retire watchdog, and a bounded drain phase.
module pipe_monitor
  import pipe_monitor_pkg::*;
#(
  parameter int NSTAGE    = 4,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 4096,
  parameter int DRAIN_MAX = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NSTAGE-1:0]            stage_v,
  input  logic                         fetch_v,
  input  logic [XLEN-1:0]              fetch_pc,
  input  logic [XLEN-1:0]              pass_pc,
  input  logic [XLEN-1:0]              fail_pc,
  input  logic [sel_width(NSTAGE)-1:0] rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic [STATE_W-1:0]           state,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic                         done
);

  localparam int SEL_W   = sel_width(NSTAGE);
  localparam int IDLE_W  = $clog2(TIMEOUT);
  localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);

  state_t              cur_state;
  state_t              next_state;
  logic                set_pass;
  logic                set_fail;
  logic                set_timeout;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                retire;
  logic                fail_hit;
  logic                pass_hit;
  logic                counting;
  logic [NSTAGE:0]     inc;
  logic [CNT_W-1:0]    counts [NSTAGE+1];
  logic [CNT_W-1:0]    rd_next;

  assign retire   = stage_v[NSTAGE-1];
  assign fail_hit = fetch_v && (fetch_pc == fail_pc);
  assign pass_hit = fetch_v && (fetch_pc == pass_pc);

  // Counting stops for good once HALT is reached; the top bit is the cycle counter.
  assign counting = enable && (cur_state != HALT);
  assign inc      = {counting, stage_v & {NSTAGE{counting}}};

  for (genvar i = 0; i <= NSTAGE; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (inc[i]),
      .q     (counts[i])
    );
  end

  // Read mux: select a counter, zero for any select past the cycle counter.
  always_comb begin
    // NOTE: default assigned first so no path leaves rd_next unassigned (no latch).
    rd_next = '0;
    for (int i = 0; i <= NSTAGE; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = counts[i];
    end
  end

  // Registered read port: shows counter values as of the previous edge.
  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_next;
  end

  // Watchdog: consecutive non-retire cycles while in RUN.
  always_ff @(posedge clk) begin
    if (!reset)                 idle_cnt <= '0;
    else if (cur_state == RUN)  idle_cnt <= retire ? '0 : idle_cnt + IDLE_W'(1);
  end

  // Drain timer: cycles spent in DRAIN so far.
  always_ff @(posedge clk) begin
    if (!reset)                  drain_cnt <= '0;
    else if (cur_state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
    else                         drain_cnt <= '0;
  end

  // Next-state logic: fail beats pass, and either beats the watchdog.
  always_comb begin
    next_state  = cur_state;
    set_pass    = 1'b0;
    set_fail    = 1'b0;
    set_timeout = 1'b0;
    case (cur_state)
      RUN: begin
        if (fail_hit) begin
          set_fail   = 1'b1;
          next_state = DRAIN;
        end else if (pass_hit) begin
          set_pass   = 1'b1;
          next_state = DRAIN;
        end else if (!retire && (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
          set_timeout = 1'b1;
          next_state  = HALT;
        end
      end
      DRAIN: begin
        if ((stage_v == '0) || (drain_cnt == DRAIN_W'(DRAIN_MAX - 1))) next_state = HALT;
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  // State register and sticky result flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= RUN;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cur_state <= next_state;
      pass      <= pass    | set_pass;
      fail      <= fail    | set_fail;
      timeout   <= timeout | set_timeout;
    end
  end

  assign state = cur_state;
  assign done  = (cur_state == HALT);

endmodule
